// File: rtl/dual_rank_mem_ctrl_pkg.sv
// Shared types and constants for the dual-rank memory controller.
// Optional statistics counters are enabled with DUAL_RANK_STATS_EN.
package dual_rank_pkg;

    localparam int WORDADDR_WIDTH_DEF = 7;
    localparam int DATA_WIDTH_DEF     = 8;
    localparam int COUNT_WIDTH        = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } state_t;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/dual_rank_mem_ctrl_if.sv
// Host-side request/response channel of the dual-rank memory controller.
interface dual_rank_mem_ctrl_if #(
    parameter int WORDADDR_WIDTH = dual_rank_pkg::WORDADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = dual_rank_pkg::DATA_WIDTH_DEF
);
    localparam int ADDR_WIDTH = WORDADDR_WIDTH + 1;

    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWr;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [DATA_WIDTH-1:0] reqWdata;
    logic                  rspValid;
    logic                  rspReady;
    logic [DATA_WIDTH-1:0] rspData;
    logic                  rspRank;

    modport master (
        output reqValid, reqWr, reqAddr, reqWdata, rspReady,
        input  reqReady, rspValid, rspData, rspRank
    );

    modport slave (
        input  reqValid, reqWr, reqAddr, reqWdata, rspReady,
        output reqReady, rspValid, rspData, rspRank
    );

endinterface

// File: rtl/dual_rank_mem_ctrl_rank_decode.sv
// Splits a host address into rank and word address and builds the
// one-hot chip-select pair, active only while a command is issued.
module rank_decode #(
    parameter int WORDADDR_WIDTH = 7
) (
    input  logic [WORDADDR_WIDTH:0]   addr,
    input  logic                      issue,
    output logic                      rank,
    output logic [WORDADDR_WIDTH-1:0] word_addr,
    output logic                      cs0,
    output logic                      cs1
);

    // The MSB selects the rank only; the word address never carries into it.
    assign rank      = addr[WORDADDR_WIDTH];
    assign word_addr = addr[WORDADDR_WIDTH-1:0];
    assign cs0       = issue & ~rank;
    assign cs1       = issue &  rank;

endmodule

// File: rtl/dual_rank_mem_ctrl.sv
// Initiator-side controller for two synchronous RAM ranks with registered read data.
// Define DUAL_RANK_STATS_EN to add saturating readCount/writeCount outputs.
module dual_rank_mem_ctrl
    import dual_rank_pkg::*;
#(
    parameter int WORDADDR_WIDTH = WORDADDR_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = WORDADDR_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    dual_rank_mem_ctrl_if.slave       host,
    output logic [WORDADDR_WIDTH-1:0] wordAddr,
    output logic [DATA_WIDTH-1:0]     dataIn,
    output logic                      wr,
    output logic                      cs0,
    output logic                      cs1,
    input  logic [DATA_WIDTH-1:0]     dataOut0,
    input  logic [DATA_WIDTH-1:0]     dataOut1
`ifdef DUAL_RANK_STATS_EN
    ,
    output logic [COUNT_WIDTH-1:0]    readCount,
    output logic [COUNT_WIDTH-1:0]    writeCount
`endif
);

    state_t                state_q;
    state_t                state_nxt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_rank_q;
    logic                  issue;
    logic                  rank;
    logic                  accept;

    assign issue  = (state_q == ISSUE);
    assign accept = (state_q == IDLE) && host.reqValid;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:    if (host.reqValid) state_nxt = ISSUE;
            ISSUE:   state_nxt = wr_q ? IDLE : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (host.rspReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; the held address and data keep driving the ranks between issues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= host.reqWr;
            addr_q  <= host.reqAddr;
            wdata_q <= host.reqWdata;
        end
    end

    rank_decode #(
        .WORDADDR_WIDTH (WORDADDR_WIDTH)
    ) u_rank_decode (
        .addr      (addr_q),
        .issue     (issue),
        .rank      (rank),
        .word_addr (wordAddr),
        .cs0       (cs0),
        .cs1       (cs1)
    );

    assign dataIn = wdata_q;
    assign wr     = issue & wr_q;

    // Rank read data is valid in the cycle after ISSUE; capture it then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_rank_q <= 1'b0;
        end else if (state_q == CAPTURE) begin
            rsp_data_q <= rank ? dataOut1 : dataOut0;
            rsp_rank_q <= rank;
        end
    end

    assign host.reqReady = (state_q == IDLE);
    assign host.rspValid = (state_q == RESP);
    assign host.rspData  = rsp_data_q;
    assign host.rspRank  = rsp_rank_q;

`ifdef DUAL_RANK_STATS_EN
    logic [COUNT_WIDTH-1:0] read_count_q;
    logic [COUNT_WIDTH-1:0] write_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_count_q  <= '0;
            write_count_q <= '0;
        end else begin
            if (issue && wr_q) write_count_q <= sat_inc(write_count_q);
            if ((state_q == RESP) && host.rspReady) read_count_q <= sat_inc(read_count_q);
        end
    end

    assign readCount  = read_count_q;
    assign writeCount = write_count_q;
`endif

endmodule

// File: doc/dual_rank_mem_ctrl.md
Name: dual_rank_mem_ctrl

Overview:
Initiator-side controller that drives two 128x8 synchronous RAM ranks over their chip-select/write/word-address port.
- Accepts single-word host requests over a valid/ready handshake.
- Decodes the rank from the address MSB and asserts exactly one chip-select for one cycle.
- Captures the selected rank's registered read data and returns it on a valid/ready response channel.
- Sits between the host/test logic and the two RAM bank instances in the dual-rank memory system.

Parameters:
- WORDADDR_WIDTH, 7, per-rank word address width.
- DATA_WIDTH, 8, data word width.
- ADDR_WIDTH, WORDADDR_WIDTH+1, host address width; MSB = rank select.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active-low.
- reqValid  in  1  host request valid.
- reqReady  out  1  controller can accept a request.
- reqWr  in  1  1 = write, 0 = read.
- reqAddr  in  ADDR_WIDTH  host word address.
- reqWdata  in  DATA_WIDTH  write data.
- rspValid  out  1  read response valid.
- rspReady  in  1  host accepts response.
- rspData  out  DATA_WIDTH  read data.
- rspRank  out  1  rank that produced rspData.
- wordAddr  out  WORDADDR_WIDTH  address to both ranks.
- dataIn  out  DATA_WIDTH  write data to both ranks.
- wr  out  1  write strobe to both ranks.
- cs0  out  1  rank 0 chip-select.
- cs1  out  1  rank 1 chip-select.
- dataOut0  in  DATA_WIDTH  rank 0 registered read data.
- dataOut1  in  DATA_WIDTH  rank 1 registered read data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - reqReady=1 after reset release.
  - rspValid=0, rspData=0, rspRank=0.
  - cs0=cs1=0, wr=0, wordAddr=0, dataIn=0.
  - Rank memory contents are not touched.
- Reset mid-operation aborts the transaction. No chip-select is asserted in the cycle after reset, and any pending response is dropped.
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid&reqReady, register reqWr, reqAddr and reqWdata, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - wordAddr=addr[WORDADDR_WIDTH-1:0] and dataIn=wdata.
  - wr=registered reqWr.
  - cs0=~addr[MSB], cs1=addr[MSB]; exactly one is high.
  - A write completes at the end of this cycle, then IDLE. Writes have no response.
  - A read goes to CAPTURE.
- CAPTURE (1 cycle):
  - cs0=cs1=0.
  - Latch rspData from dataOut1 if rank=1, else from dataOut0.
  - rspRank=rank; go to RESP.
- RESP:
  - rspValid=1, with rspData and rspRank held stable.
  - On rspReady, go to IDLE; rspValid drops next cycle.
  - No bypass: reqReady rises the cycle after the handshake.
- reqReady=0 in ISSUE, CAPTURE and RESP; reqValid is ignored there.
- Latency:
  - Write: 2 cycles per request (accept, issue).
  - Read: accept edge to rspValid high = 3 cycles; minimum 4 cycles per read.
- Chip-selects, wr, wordAddr and dataIn are registered outputs (no combinational path from request ports). Outside ISSUE: cs0=cs1=0 and wr=0; wordAddr and dataIn hold their last values.
- Boundaries:
  - Address 0x7F maps to rank0 word 127; 0x80 maps to rank1 word 0; 0xFF maps to rank1 word 127.
  - Address wraps within the rank; no cross-rank carry.
- rspReady held high continuously is legal; the response is then consumed in its first RESP cycle.

Optional Feature:
- Macro: DUAL_RANK_STATS_EN.
- Defined:
  - Adds outputs readCount and writeCount, each 16 bits.
  - Each increments on completion of its operation type: read at the RESP handshake, write at the end of ISSUE.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: the ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package dual_rank_pkg:
  - state enum {IDLE, ISSUE, CAPTURE, RESP}.
  - Default width constants (WORDADDR_WIDTH=7, DATA_WIDTH=8).
  - Counter width constant (16).
- One sub-module, rank_decode (combinational):
  - Splits the host address into rank and word address.
  - Produces the one-hot cs pair gated by issue.
- The FSM and response register stay in the top module.

Test Plan:
- Write 0xA5 to addr 0x05 then read 0x05 -> one ISSUE cycle with cs0=1, cs1=0, wr=1, wordAddr=0x05; then rspValid 3 cycles after read accept, rspData=0xA5, rspRank=0.
- Write 0x11 to 0x7F and 0x22 to 0x80, then read both -> 0x11 returned with rspRank=0 and 0x22 with rspRank=1; cs1 never asserted for 0x7F, and addr 0x80 drives wordAddr=0x00.
- Read response with rspReady held low 5 cycles -> rspValid stays 1 and rspData stable; reqReady=0 throughout; a reqValid pulse meanwhile is ignored (no cs).
- Back-to-back writes with reqValid held high -> one accept every 2 cycles; cs active 1 of every 2 cycles.
- Assert rst_n=0 during CAPTURE of a read -> next cycle rspValid=0, cs0=cs1=0, reqReady=1 after release; no stale response is ever presented.
- With DUAL_RANK_STATS_EN: 3 writes and 2 reads -> writeCount=3, readCount=2; preload each counter near 0xFFFF and run further operations -> both saturate at 0xFFFF.
